// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module : hazard_forward_unit
// Desc   : ID-stage bypass selects, load-use / HI-LO stall control and
//          mult/div occupancy tracking with a saturating stall counter.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_forward_unit #(
    parameter int AW         = 5,
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_is_md,
    input  logic             id_uses_hilo,
    input  logic             ex_valid,
    input  logic             ex_wr_en,
    input  logic             ex_is_load,
    input  logic [AW-1:0]    ex_wd,
    input  logic             mem_valid,
    input  logic             mem_wr_en,
    input  logic             mem_is_load,
    input  logic [AW-1:0]    mem_wd,
    input  logic             wb_valid,
    input  logic             wb_wr_en,
    input  logic [AW-1:0]    wb_wd,
    input  logic             id_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int               MDC_W     = 8;
    localparam logic [0:0]       c_IDLE    = 1'b0;
    localparam logic [0:0]       c_BUSY    = 1'b1;
    localparam logic [MDC_W-1:0] c_MD_LOAD = MDC_W'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [MDC_W-1:0] md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic w_rs_ex, w_rs_mem, w_rs_wb;
    logic w_rt_ex, w_rt_mem, w_rt_wb;
    logic w_lu_rs, w_lu_rt, w_hilo_haz, w_stall, w_issue, w_md_busy;

    function automatic logic f_match(input logic v, input logic we,
                                     input logic [AW-1:0] wd,
                                     input logic [AW-1:0] src, input logic used);
        return v & we & (wd == src) & (src != '0) & used;
    endfunction

    function automatic logic [1:0] f_sel(input logic m_ex, input logic m_mem,
                                         input logic m_wb);
        if (m_ex)       return 2'b01;
        else if (m_mem) return 2'b10;
        else if (m_wb)  return 2'b11;
        else            return 2'b00;
    endfunction

    assign w_rs_ex  = f_match(ex_valid,  ex_wr_en,  ex_wd,  id_rs, id_rs_used);
    assign w_rs_mem = f_match(mem_valid, mem_wr_en, mem_wd, id_rs, id_rs_used);
    assign w_rs_wb  = f_match(wb_valid,  wb_wr_en,  wb_wd,  id_rs, id_rs_used);
    assign w_rt_ex  = f_match(ex_valid,  ex_wr_en,  ex_wd,  id_rt, id_rt_used);
    assign w_rt_mem = f_match(mem_valid, mem_wr_en, mem_wd, id_rt, id_rt_used);
    assign w_rt_wb  = f_match(wb_valid,  wb_wr_en,  wb_wd,  id_rt, id_rt_used);

    // A younger non-load EX write supersedes an older MEM load of the same register.
    assign w_lu_rs = (w_rs_ex & ex_is_load) |
                     (w_rs_mem & mem_is_load & ~(w_rs_ex & ~ex_is_load));
    assign w_lu_rt = (w_rt_ex & ex_is_load) |
                     (w_rt_mem & mem_is_load & ~(w_rt_ex & ~ex_is_load));

    assign w_md_busy  = (state_q == c_BUSY);
    assign w_hilo_haz = id_valid & (id_is_md | id_uses_hilo) & w_md_busy;
    assign w_stall    = rst_n & id_valid & ~id_flush & (w_lu_rs | w_lu_rt | w_hilo_haz);
    assign w_issue    = id_valid & id_is_md & ~w_stall & ~id_flush;

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            c_IDLE: begin
                if (w_issue) begin
                    state_d  = c_BUSY;
                    md_cnt_d = c_MD_LOAD;
                end
            end
            c_BUSY: begin
                if (md_cnt_q == '0) state_d  = c_IDLE;
                else                md_cnt_d = md_cnt_q - MDC_W'(1);
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_stall && (stall_cnt_q != c_CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_IDLE;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_a_sel = rst_n ? f_sel(w_rs_ex, w_rs_mem, w_rs_wb) : 2'b00;
    assign fwd_b_sel = rst_n ? f_sel(w_rt_ex, w_rt_mem, w_rt_wb) : 2'b00;
    assign stall_if  = w_stall;
    assign stall_id  = w_stall;
    assign bubble_ex = w_stall;
    assign md_busy   = rst_n & w_md_busy;
    assign md_done   = rst_n & w_md_busy & (md_cnt_q == '0);
    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_forward_unit
// Desc   : Table-driven and sequence checks of hazard_forward_unit.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hazard_forward_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid, id_rs_used, id_rt_used, id_is_md, id_uses_hilo;
    logic [4:0] id_rs, id_rt;
    logic       ex_valid, ex_wr_en, ex_is_load;
    logic [4:0] ex_wd;
    logic       mem_valid, mem_wr_en, mem_is_load;
    logic [4:0] mem_wd;
    logic       wb_valid, wb_wr_en;
    logic [4:0] wb_wd;
    logic       id_flush;

    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall_if, stall_id, bubble_ex, md_busy, md_done;
    logic [15:0] stall_cnt;

    logic [1:0]  s_fwd_a_sel, s_fwd_b_sel;
    logic        s_stall_if, s_stall_id, s_bubble_ex, s_md_busy, s_md_done;
    logic [2:0]  s_stall_cnt;

    typedef logic [27:0] obs_t;

    typedef struct {
        string      name;
        logic       idv;
        logic [4:0] rs;
        logic       rsu;
        logic [4:0] rt;
        logic       rtu;
        logic       exv, exw, exl;
        logic [4:0] exd;
        logic       memv, memw, meml;
        logic [4:0] memd;
        logic       wbv, wbw;
        logic [4:0] wbd;
        logic       flush;
        logic [1:0] ea, eb;
        logic       es;
    } vec_t;

    vec_t  vt[13];
    obs_t  sb_q[$];
    string nm_q[$];
    int    n_pass  = 0;
    int    n_total = 0;
    logic [15:0] exp_cnt;
    logic [2:0]  exp_cnt_s;

    hazard_forward_unit #(.AW(5), .MD_LATENCY(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_is_md(id_is_md), .id_uses_hilo(id_uses_hilo),
        .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wd(ex_wd),
        .mem_valid(mem_valid), .mem_wr_en(mem_wr_en), .mem_is_load(mem_is_load), .mem_wd(mem_wd),
        .wb_valid(wb_valid), .wb_wr_en(wb_wr_en), .wb_wd(wb_wd),
        .id_flush(id_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
    );

    hazard_forward_unit #(.AW(5), .MD_LATENCY(4), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_is_md(id_is_md), .id_uses_hilo(id_uses_hilo),
        .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wd(ex_wd),
        .mem_valid(mem_valid), .mem_wr_en(mem_wr_en), .mem_is_load(mem_is_load), .mem_wd(mem_wd),
        .wb_valid(wb_valid), .wb_wr_en(wb_wr_en), .wb_wd(wb_wd),
        .id_flush(id_flush),
        .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
        .stall_if(s_stall_if), .stall_id(s_stall_id), .bubble_ex(s_bubble_ex),
        .md_busy(s_md_busy), .md_done(s_md_done), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        id_is_md = 1'b0; id_uses_hilo = 1'b0;
        ex_valid = 1'b0; ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_wd = '0;
        mem_valid = 1'b0; mem_wr_en = 1'b0; mem_is_load = 1'b0; mem_wd = '0;
        wb_valid = 1'b0; wb_wr_en = 1'b0; wb_wd = '0;
        id_flush = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        clear_inputs();
        id_valid = v.idv; id_rs = v.rs; id_rs_used = v.rsu; id_rt = v.rt; id_rt_used = v.rtu;
        ex_valid = v.exv; ex_wr_en = v.exw; ex_is_load = v.exl; ex_wd = v.exd;
        mem_valid = v.memv; mem_wr_en = v.memw; mem_is_load = v.meml; mem_wd = v.memd;
        wb_valid = v.wbv; wb_wr_en = v.wbw; wb_wd = v.wbd;
        id_flush = v.flush;
    endtask

    task automatic check_out();
        obs_t  e;
        obs_t  act;
        string nm;
        e   = sb_q.pop_front();
        nm  = nm_q.pop_front();
        act = {fwd_a_sel, fwd_b_sel, stall_if, stall_id, bubble_ex,
               md_busy, md_done, stall_cnt, s_stall_cnt};
        n_total++;
        if (act === e) n_pass++;
        else $display("FAIL %s: got %h expected %h (a,b,sif,sid,bub,busy,done,cnt16,cnt3)",
                      nm, act, e);
    endtask

    // Inputs are already driven; check after settling, then advance one edge.
    task automatic step(input string nm, input logic [1:0] ea, input logic [1:0] eb,
                        input logic es, input logic ebusy, input logic edone);
        sb_q.push_back({ea, eb, es, es, es, ebusy, edone, exp_cnt, exp_cnt_s});
        nm_q.push_back(nm);
        #3;
        check_out();
        if (es) begin
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (exp_cnt_s != 3'd7)   exp_cnt_s = exp_cnt_s + 3'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          name          idv  rs   rsu  rt   rtu  exv  exw  exl  exd   memv memw meml memd  wbv  wbw  wbd  fl   ea     eb     es
        vt[0]  = '{"prio_ex",     1'b1,5'd5,1'b1,5'd5,1'b1,1'b1,1'b1,1'b0,5'd5, 1'b1,1'b1,1'b0,5'd5, 1'b1,1'b1,5'd5,1'b0,2'b01,2'b01,1'b0};
        vt[1]  = '{"prio_mem",    1'b1,5'd5,1'b1,5'd5,1'b1,1'b0,1'b1,1'b0,5'd5, 1'b1,1'b1,1'b0,5'd5, 1'b1,1'b1,5'd5,1'b0,2'b10,2'b10,1'b0};
        vt[2]  = '{"prio_wb",     1'b1,5'd5,1'b1,5'd5,1'b1,1'b0,1'b1,1'b0,5'd5, 1'b0,1'b1,1'b0,5'd5, 1'b1,1'b1,5'd5,1'b0,2'b11,2'b11,1'b0};
        vt[3]  = '{"r0_guard",    1'b1,5'd0,1'b1,5'd0,1'b1,1'b1,1'b1,1'b1,5'd0, 1'b1,1'b1,1'b1,5'd0, 1'b1,1'b1,5'd0,1'b0,2'b00,2'b00,1'b0};
        vt[4]  = '{"shadow_ld",   1'b1,5'd3,1'b1,5'd1,1'b1,1'b1,1'b1,1'b0,5'd3, 1'b1,1'b1,1'b1,5'd3, 1'b0,1'b0,5'd0,1'b0,2'b01,2'b00,1'b0};
        vt[5]  = '{"ex_load_rs",  1'b1,5'd3,1'b1,5'd2,1'b1,1'b1,1'b1,1'b1,5'd3, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,5'd0,1'b0,2'b01,2'b00,1'b1};
        vt[6]  = '{"mem_load_rt", 1'b1,5'd1,1'b1,5'd7,1'b1,1'b1,1'b1,1'b0,5'd9, 1'b1,1'b1,1'b1,5'd7, 1'b0,1'b0,5'd0,1'b0,2'b00,2'b10,1'b1};
        vt[7]  = '{"unused_ops",  1'b1,5'd3,1'b0,5'd4,1'b0,1'b1,1'b1,1'b1,5'd3, 1'b1,1'b1,1'b1,5'd4, 1'b0,1'b0,5'd0,1'b0,2'b00,2'b00,1'b0};
        vt[8]  = '{"flush_ld",    1'b1,5'd3,1'b1,5'd0,1'b0,1'b1,1'b1,1'b1,5'd3, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,5'd0,1'b1,2'b01,2'b00,1'b0};
        vt[9]  = '{"idv0_ld",     1'b0,5'd3,1'b1,5'd0,1'b0,1'b1,1'b1,1'b1,5'd3, 1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,5'd0,1'b0,2'b01,2'b00,1'b0};
        vt[10] = '{"ex_wren0",    1'b1,5'd4,1'b1,5'd0,1'b0,1'b1,1'b0,1'b0,5'd4, 1'b1,1'b1,1'b0,5'd4, 1'b0,1'b0,5'd0,1'b0,2'b10,2'b00,1'b0};
        vt[11] = '{"mixed",       1'b1,5'd2,1'b1,5'd9,1'b1,1'b0,1'b1,1'b0,5'd9, 1'b1,1'b1,1'b0,5'd9, 1'b1,1'b1,5'd2,1'b0,2'b11,2'b10,1'b0};
        vt[12] = '{"ex_mem_ld_rt",1'b1,5'd0,1'b0,5'd8,1'b1,1'b1,1'b1,1'b1,5'd8, 1'b1,1'b1,1'b1,5'd8, 1'b0,1'b0,5'd0,1'b0,2'b00,2'b01,1'b1};

        exp_cnt   = '0;
        exp_cnt_s = '0;
        clear_inputs();
        rst_n = 1'b0;
        // Reset held with a live load-use hazard on the inputs: everything must stay quiet.
        apply_vec(vt[5]);
        @(posedge clk);
        #1;
        step("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            apply_vec(vt[i]);
            step(vt[i].name, vt[i].ea, vt[i].eb, vt[i].es, 1'b0, 1'b0);
        end

        // Load-use: lw r3 in EX, then MEM (bubble behind it), then WB.
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd3; id_rs_used = 1'b1;
        ex_valid = 1'b1; ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wd = 5'd3;
        step("lu_ex", 2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        ex_valid = 1'b0; ex_wr_en = 1'b0; ex_is_load = 1'b0;
        mem_valid = 1'b1; mem_wr_en = 1'b1; mem_is_load = 1'b1; mem_wd = 5'd3;
        step("lu_mem", 2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
        mem_valid = 1'b0; mem_wr_en = 1'b0; mem_is_load = 1'b0;
        wb_valid = 1'b1; wb_wr_en = 1'b1; wb_wd = 5'd3;
        step("lu_wb", 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);

        // Flushed mult must not issue.
        clear_inputs();
        id_valid = 1'b1; id_is_md = 1'b1; id_flush = 1'b1;
        step("md_flush", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        clear_inputs();
        step("md_noissue", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // mult issue, mflo waits out 4 busy cycles.
        id_valid = 1'b1; id_is_md = 1'b1;
        step("mult_issue", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        id_is_md = 1'b0; id_uses_hilo = 1'b1;
        for (int i = 0; i < 4; i++)
            step("mflo_stall", 2'b00, 2'b00, 1'b1, 1'b1, (i == 3));
        step("mflo_go", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // div issue followed directly by a second div.
        id_uses_hilo = 1'b0; id_is_md = 1'b1;
        step("div1_issue", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step("div2_stall", 2'b00, 2'b00, 1'b1, 1'b1, (i == 3));
        step("div2_issue", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        clear_inputs();
        step("div2_busy", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of the busy window.
        rst_n     = 1'b0;
        exp_cnt   = '0;
        exp_cnt_s = '0;
        step("rst_mid", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            step("post_rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Ten consecutive stall cycles: 16-bit counter reaches 10, 3-bit one pins at 7.
        id_valid = 1'b1; id_rs = 5'd3; id_rs_used = 1'b1;
        ex_valid = 1'b1; ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wd = 5'd3;
        for (int i = 0; i < 10; i++)
            step("sat_stall", 2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        clear_inputs();
        step("sat_final", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
